mor1kx_shadow_stack_ctrl: RTL and testbench
===========================================

MOR1KX_SHADOW_STACK_CTRL -- requirements
Module: mor1kx_shadow_stack_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, return-address width.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 5, stack address width; DEPTH = 2^DEPTH_WIDTH entries.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 clear_i  input  1  synchronous flush: empties the stack and clears the sticky flags.
REQ-007 push_i  input  1  call event; push push_addr_i.
REQ-008 push_addr_i  input  DATA_WIDTH  return address to save (link register value).
REQ-009 pop_i  input  1  return event; check pop_addr_i against top of stack.
REQ-010 pop_addr_i  input  DATA_WIDTH  actual return target.
REQ-011 ready_o  output  1  high when in IDLE.
REQ-012 mem_waddr_o, mem_raddr_o  output  DEPTH_WIDTH each  RAM write/read address.
REQ-013 mem_we_o, mem_re_o  output  1 each  RAM write/read enable.
REQ-014 mem_din_o  output  DATA_WIDTH  RAM write data.
REQ-015 mem_dout_i  input  DATA_WIDTH  RAM read data; registered RAM, valid in the cycle after the re edge.
REQ-016 check_valid_o  output  1  one-cycle pulse marking a completed pop check.
REQ-017 mismatch_o  output  1  check result; meaningful only while check_valid_o is high.
REQ-018 violation_o, overflow_o, underflow_o  output  1 each  sticky error flags.
REQ-019 count_o  output  DEPTH_WIDTH+1  current number of stacked entries.

Function
REQ-020 SHALL implement FSM states IDLE and CHECK; ready_o = (state==IDLE).
REQ-021 SHALL accept push when ready_o && push_i; push SHALL take priority over a simultaneous pop_i, and that pop SHALL NOT be accepted.
REQ-022 SHALL accept pop when ready_o && pop_i && !push_i && !clear_i.
REQ-023 clear_i SHALL have priority over push and pop and SHALL be honoured in any state; it forces IDLE, count 0, all sticky flags 0, and no check pulse.
REQ-024 Accepted push with count<DEPTH: mem_we_o=1, mem_waddr_o=count[DEPTH_WIDTH-1:0], mem_din_o=push_addr_i in the same cycle (combinational); count increments at the edge; single-cycle operation.
REQ-025 Accepted push with count==DEPTH: no write, count unchanged, overflow_o and violation_o set at the edge.
REQ-026 Accepted pop with count>0: mem_re_o=1, mem_raddr_o=count-1 in the same cycle; pop_addr_i latched; state goes to CHECK.
REQ-027 In CHECK the block SHALL compare mem_dout_i with the latched address, then at the edge pulse check_valid_o for one cycle and decrement count.
REQ-028 On that same edge, mismatch_o = (mem_dout_i != latched address); a mismatch also sets violation_o. State returns to IDLE.
REQ-029 Pop latency: check_valid_o SHALL be high in the second cycle after acceptance; throughput is one pop per 2 cycles.
REQ-030 Accepted pop with count==0: no RAM read; at the edge set underflow_o and violation_o, and pulse check_valid_o with mismatch_o=1 in the next cycle; state stays IDLE.
REQ-031 mem_we_o and mem_re_o SHALL never be high in the same cycle.
REQ-032 When mem_we_o/mem_re_o are low, mem_waddr_o, mem_raddr_o and mem_din_o SHALL be driven 0.
REQ-033 Sticky flags SHALL be cleared only by rst or clear_i.

Reset
REQ-034 rst SHALL asynchronously force state IDLE, count_o=0, and check_valid_o, mismatch_o, violation_o, overflow_o and underflow_o all 0.
REQ-035 rst asserted during CHECK SHALL abort the check: no check_valid_o pulse, and the RAM contents are don't-care.

Verification
REQ-036 Push 0x100, then pop 0x100 -> check_valid_o=1 two cycles after pop acceptance, mismatch_o=0, count_o returns 0, violation_o=0.
REQ-037 Push 0x100, 0x200; pop 0x200; pop 0x104 -> first check mismatch_o=0; second check mismatch_o=1; violation_o sticky 1.
REQ-038 With DEPTH_WIDTH=2: 5 pushes -> count_o=4, overflow_o=1, 5th value not written (mem_we_o low).
REQ-039 Pop on empty stack -> next cycle check_valid_o=1, mismatch_o=1, underflow_o=1, mem_re_o never asserted.
REQ-040 push_i and pop_i together in IDLE -> push performed, pop ignored; holding pop_i one more cycle -> pop accepted and compares against the just-pushed value.
REQ-041 rst asserted in CHECK -> immediately count_o=0, all flags 0, no check_valid_o; clear_i with flags set -> flags 0 next cycle.

Source files
------------

// File: rtl/mor1kx_shadow_stack_ctrl.sv
// Shadow return-address stack controller: pushes on calls, checks returns
// against the saved address held in an external registered RAM.
module mor1kx_shadow_stack_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [DATA_WIDTH-1:0]  push_addr_i,
  input  logic                   pop_i,
  input  logic [DATA_WIDTH-1:0]  pop_addr_i,
  output logic                   ready_o,
  output logic [DEPTH_WIDTH-1:0] mem_waddr_o,
  output logic [DEPTH_WIDTH-1:0] mem_raddr_o,
  output logic                   mem_we_o,
  output logic                   mem_re_o,
  output logic [DATA_WIDTH-1:0]  mem_din_o,
  input  logic [DATA_WIDTH-1:0]  mem_dout_i,
  output logic                   check_valid_o,
  output logic                   mismatch_o,
  output logic                   violation_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic [DEPTH_WIDTH:0]   count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = (DEPTH_WIDTH+1)'(DEPTH);

  typedef enum logic {IDLE, CHECK} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  ret_addr;
  logic [DEPTH_WIDTH:0]   count_m1;
  logic                   full, empty, push_acc, pop_acc, miss;

  assign ready_o  = (state == IDLE);
  assign full     = (count_o == DEPTH_CNT);
  assign empty    = (count_o == '0);
  assign count_m1 = count_o - 1'b1;
  assign push_acc = ready_o && push_i && !clear_i;
  assign pop_acc  = ready_o && pop_i && !push_i && !clear_i;
  assign miss     = (mem_dout_i != ret_addr);

  // RAM strobes are combinational so the write/read lands on the accepting edge
  assign mem_we_o    = push_acc && !full;
  assign mem_re_o    = pop_acc && !empty;
  assign mem_waddr_o = mem_we_o ? count_o[DEPTH_WIDTH-1:0] : '0;
  assign mem_din_o   = mem_we_o ? push_addr_i : '0;
  assign mem_raddr_o = mem_re_o ? count_m1[DEPTH_WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count_o       <= '0;
      ret_addr      <= '0;
      check_valid_o <= 1'b0;
      mismatch_o    <= 1'b0;
      violation_o   <= 1'b0;
      overflow_o    <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      check_valid_o <= 1'b0;
      if (clear_i) begin
        state       <= IDLE;
        count_o     <= '0;
        mismatch_o  <= 1'b0;
        violation_o <= 1'b0;
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (push_acc) begin
              if (!full) begin
                count_o <= count_o + 1'b1;
              end else begin
                overflow_o  <= 1'b1;
                violation_o <= 1'b1;
              end
            end else if (pop_acc) begin
              if (!empty) begin
                ret_addr <= pop_addr_i;
                state    <= CHECK;
              end else begin
                // empty-stack return is reported as a failed check
                underflow_o   <= 1'b1;
                violation_o   <= 1'b1;
                check_valid_o <= 1'b1;
                mismatch_o    <= 1'b1;
              end
            end
          end
          CHECK: begin
            check_valid_o <= 1'b1;
            mismatch_o    <= miss;
            if (miss) violation_o <= 1'b1;
            count_o <= count_m1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_shadow_stack_ctrl.sv
// Bench for the shadow stack controller: queue-based stack model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mor1kx_shadow_stack_ctrl;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
  logic [DW-1:0] push_addr_i = '0, pop_addr_i = '0;
  logic          ready_o, mem_we_o, mem_re_o;
  logic [AW-1:0] mem_waddr_o, mem_raddr_o;
  logic [DW-1:0] mem_din_o, mem_dout_i;
  logic          check_valid_o, mismatch_o, violation_o, overflow_o, underflow_o;
  logic [AW:0]   count_o;

  int tests = 0, fails = 0;

  mor1kx_shadow_stack_ctrl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .push_i(push_i),
    .push_addr_i(push_addr_i), .pop_i(pop_i), .pop_addr_i(pop_addr_i),
    .ready_o(ready_o), .mem_waddr_o(mem_waddr_o), .mem_raddr_o(mem_raddr_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_din_o(mem_din_o),
    .mem_dout_i(mem_dout_i), .check_valid_o(check_valid_o),
    .mismatch_o(mismatch_o), .violation_o(violation_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Registered RAM behind the controller
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_waddr_o] <= mem_din_o;
    if (mem_re_o) mem_dout_i <= ram[mem_raddr_o];
  end

  // Behavioural model: a queue is the stack; a pending pop remembers the
  // expected top and the claimed target until its check completes.
  logic [DW-1:0] stk[$];
  bit            m_busy = 0, m_cv = 0, m_mm = 0, m_viol = 0, m_ovf = 0, m_unf = 0;
  logic [DW-1:0] m_top, m_claim;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stk.delete();
      m_busy = 0; m_cv = 0; m_mm = 0; m_viol = 0; m_ovf = 0; m_unf = 0;
    end else if (clear_i) begin
      stk.delete();
      m_busy = 0; m_cv = 0; m_mm = 0; m_viol = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_cv = 0;
      if (m_busy) begin
        m_cv = 1; m_mm = (m_top != m_claim);
        if (m_mm) m_viol = 1;
        void'(stk.pop_back());
        m_busy = 0;
      end else if (push_i) begin
        if (stk.size() < DEPTH) stk.push_back(push_addr_i);
        else begin m_ovf = 1; m_viol = 1; end
      end else if (pop_i) begin
        if (stk.size() > 0) begin
          m_busy = 1; m_top = stk[$]; m_claim = pop_addr_i;
        end else begin
          m_unf = 1; m_viol = 1; m_cv = 1; m_mm = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    bit we, re;
    int n;
    n  = stk.size();
    we = !m_busy && push_i && !clear_i && n < DEPTH;
    re = !m_busy && pop_i && !push_i && !clear_i && n > 0;
    chk("ready", ready_o, !m_busy);
    chk("count", count_o, n);
    chk("check_valid", check_valid_o, m_cv);
    if (m_cv) chk("mismatch", mismatch_o, m_mm);
    chk("violation", violation_o, m_viol);
    chk("overflow", overflow_o, m_ovf);
    chk("underflow", underflow_o, m_unf);
    chk("mem_we", mem_we_o, we);
    chk("mem_re", mem_re_o, re);
    chk("waddr", mem_waddr_o, we ? n : 0);
    chk("din", mem_din_o, we ? push_addr_i : 0);
    chk("raddr", mem_raddr_o, re ? n - 1 : 0);
    chk("we_re_excl", mem_we_o && mem_re_o, 0);
  end

  task automatic cyc(input bit c, input bit pu, input logic [DW-1:0] pa,
                     input bit po, input logic [DW-1:0] oa);
    clear_i = c; push_i = pu; push_addr_i = pa; pop_i = po; pop_addr_i = oa;
    @(posedge clk); #1;
    clear_i = 0; push_i = 0; pop_i = 0; push_addr_i = '0; pop_addr_i = '0;
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0); endtask
  task automatic clr();  cyc(1, 0, 0, 0, 0); endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_flags", {check_valid_o, violation_o, overflow_o, underflow_o}, 0);
    rst = 0;
    idle();

    // single push/pop round trip
    cyc(0, 1, 32'h100, 0, 0);
    cyc(0, 0, 0, 1, 32'h100);
    chk("rt_busy", ready_o, 0);
    idle();
    chk("rt_cv", check_valid_o, 1);
    chk("rt_mm", mismatch_o, 0);
    chk("rt_count", count_o, 0);
    chk("rt_viol", violation_o, 0);
    idle();
    chk("rt_pulse_end", check_valid_o, 0);

    // nested calls with a corrupted second return
    clr();
    cyc(0, 1, 32'h100, 0, 0);
    cyc(0, 1, 32'h200, 0, 0);
    cyc(0, 0, 0, 1, 32'h200);
    idle();
    chk("nest_cv1", check_valid_o, 1);
    chk("nest_mm1", mismatch_o, 0);
    cyc(0, 0, 0, 1, 32'h104);
    idle();
    chk("nest_cv2", check_valid_o, 1);
    chk("nest_mm2", mismatch_o, 1);
    chk("nest_viol", violation_o, 1);
    idle(); idle();
    chk("nest_sticky", violation_o, 1);

    // overflow: fifth push is dropped
    clr();
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h40 + i, 0, 0);
    push_i = 1; push_addr_i = 32'hDEAD;
    #1;
    chk("ovf_no_we", mem_we_o, 0);
    @(posedge clk); #1;
    push_i = 0; push_addr_i = '0;
    chk("ovf_count", count_o, 4);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_viol", violation_o, 1);
    cyc(0, 0, 0, 1, 32'h43);
    idle();
    chk("ovf_top_ok", mismatch_o, 0);

    // underflow
    clr();
    pop_i = 1; pop_addr_i = 32'h55;
    #1;
    chk("unf_no_re", mem_re_o, 0);
    @(posedge clk); #1;
    pop_i = 0; pop_addr_i = '0;
    chk("unf_cv", check_valid_o, 1);
    chk("unf_mm", mismatch_o, 1);
    chk("unf_flag", underflow_o, 1);
    chk("unf_ready", ready_o, 1);

    // push wins over simultaneous pop; held pop then checks the new value
    clr();
    cyc(0, 1, 32'h300, 1, 32'h300);
    chk("prio_count", count_o, 1);
    chk("prio_ready", ready_o, 1);
    cyc(0, 0, 0, 1, 32'h300);
    idle();
    chk("prio_cv", check_valid_o, 1);
    chk("prio_mm", mismatch_o, 0);
    chk("prio_count0", count_o, 0);

    // reset aborts a check in flight
    cyc(0, 0, 0, 1, 32'h1);
    cyc(0, 1, 32'h10, 0, 0);
    cyc(0, 0, 0, 1, 32'h10);
    rst = 1;
    #1;
    chk("rst_chk_count", count_o, 0);
    chk("rst_chk_flags", {violation_o, overflow_o, underflow_o}, 0);
    chk("rst_chk_ready", ready_o, 1);
    @(posedge clk); #1;
    rst = 0;
    chk("rst_chk_nocv", check_valid_o, 0);
    idle();
    chk("rst_chk_nocv2", check_valid_o, 0);

    // clear wipes sticky flags, also mid-check
    cyc(0, 0, 0, 1, 32'h2);
    chk("clr_pre", violation_o, 1);
    clr();
    chk("clr_flags", {violation_o, overflow_o, underflow_o}, 0);
    cyc(0, 1, 32'h20, 0, 0);
    cyc(0, 0, 0, 1, 32'h99);
    clr();
    chk("clr_chk_nocv", check_valid_o, 0);
    chk("clr_chk_count", count_o, 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 2) == 0,
          32'h1000 + 4 * $urandom_range(0, 3), $urandom_range(0, 1) == 1,
          32'h1000 + 4 * $urandom_range(0, 3));
    repeat (3) idle();

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
